dram_stream_reader: RTL and testbench
=====================================

DRAM_STREAM_READER -- requirements
Module: dram_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data/FIFO word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning Avalon byte-address width.
REQ-003 The block SHALL have parameter BURST_LOG2, default 3, meaning max burst = 2^BURST_LOG2 beats.
REQ-004 The block SHALL have parameter FIFO_LOG2, default 9, meaning FIFO depth = 2^FIFO_LOG2 words.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse; launches a job when idle.
REQ-009 base_addr  in  ADDR_W  job start byte address, sampled at start.
REQ-010 num_words  in  32  job word count, sampled at start.
REQ-011 stride_en  in  1  0 = contiguous bursts; 1 = single-beat strided reads; sampled at start.
REQ-012 stride  in  ADDR_W  byte step between strided words, sampled at start.
REQ-013 abort  in  1  one-cycle pulse; terminates the current job.
REQ-014 busy  out  1  job or abort drain in progress.
REQ-015 done  out  1  high when idle with no job pending.
REQ-016 overflow  out  1  sticky error: beat arrived with FIFO full.
REQ-017 master_address / master_read / master_burstcount  out  ADDR_W / 1 / BURST_LOG2+1  Avalon read command.
REQ-018 master_readdata / master_waitrequest / master_readdatavalid  in  DATA_W / 1 / 1  Avalon response.
REQ-019 rd_req  in  1  consumer pop.
REQ-020 rd_data / fifo_empty / fifo_level  out  DATA_W / 1 / FIFO_LOG2+1  show-ahead head word, empty flag, occupancy.

Function
REQ-021 The block SHALL implement states IDLE, REQ, RUN, DRAIN.
REQ-022 IDLE: start -> latch inputs; num_words==0 -> stay IDLE (no bus traffic), else -> RUN; start while not IDLE SHALL be ignored.
REQ-023 RUN: issue when words_to_issue>0 and fifo_level + outstanding + len <= 2^FIFO_LOG2 -> REQ; len = 1 if stride_en, else min(2^BURST_LOG2, words_to_issue).
REQ-024 REQ: master_read=1, address and burstcount held stable until a cycle with master_waitrequest=0, then master_read=0 next cycle -> RUN.
REQ-025 On command acceptance: outstanding += len, words_to_issue -= len, address += len*DATA_W/8 (contiguous) or += stride (strided), wrapping modulo 2^ADDR_W.
REQ-026 Multiple bursts SHALL be outstanding simultaneously; issue is not blocked by pending responses beyond the credit rule.
REQ-027 Each master_readdatavalid beat SHALL be written to the FIFO, outstanding -= 1, words_to_receive -= 1 (same-cycle accept and beat both apply).
REQ-028 RUN -> IDLE when words_to_issue==0, outstanding==0 and words_to_receive==0.
REQ-029 abort in REQ or RUN: if in REQ, keep master_read until accepted; then -> DRAIN; no new commands.
REQ-030 DRAIN: beats discarded (not written) until outstanding==0; then FIFO flushed (level 0) -> IDLE. abort in IDLE ignored; abort and start same cycle: abort wins.
REQ-031 FIFO: rd_data is head word when !fifo_empty; rd_req when empty ignored; simultaneous push/pop leaves level unchanged; pointers wrap modulo depth.
REQ-032 A beat arriving at full FIFO SHALL be dropped and set overflow (cleared only by reset).
REQ-033 busy = state != IDLE; done = state == IDLE.

Reset
REQ-034 reset SHALL force IDLE, master_read=0, master_address=0, master_burstcount=0, all counters 0, FIFO empty (fifo_level=0, fifo_empty=1), rd_data=0, overflow=0, busy=0, done=1.
REQ-035 reset mid-job SHALL abandon in-flight bursts immediately; stale beats after reset release are written only if a new job is running.

Verification
REQ-036 Contiguous: base 0x1000, 20 words, no waitrequest -> bursts len 8@0x1000, 8@0x1020, 4@0x1040; FIFO holds 20 words in order; done re-asserts.
REQ-037 Strided: base 0x0, stride 0x100, 3 words -> three len-1 reads at 0x000, 0x100, 0x200.
REQ-038 Backpressure: FIFO_LOG2=4, consumer idle, 40 words -> issue stops at 16 reserved words; resumes only after pops; overflow stays 0.
REQ-039 waitrequest held 5 cycles -> address/burstcount stable for all 5; exactly one burst counted.
REQ-040 Abort with 2 bursts outstanding -> no new commands; 16 beats discarded; FIFO level 0; IDLE.
REQ-041 num_words=0 start -> no master_read; done stays 1; simultaneous push/pop at level 7 -> level remains 7.

Source files
------------

// File: rtl/dram_stream_reader.sv
// Avalon-MM read engine: streams a job of words (contiguous bursts or strided single beats)
// into a show-ahead FIFO, issuing a command only when FIFO space is reserved for all its beats.
module dram_stream_reader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BURST_LOG2 = 3,
    parameter int FIFO_LOG2  = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [31:0]         num_words,
    input  logic                stride_en,
    input  logic [ADDR_W-1:0]   stride,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [ADDR_W-1:0]   master_address,
    output logic                master_read,
    output logic [BURST_LOG2:0] master_burstcount,
    input  logic [DATA_W-1:0]   master_readdata,
    input  logic                master_waitrequest,
    input  logic                master_readdatavalid,
    input  logic                rd_req,
    output logic [DATA_W-1:0]   rd_data,
    output logic                fifo_empty,
    output logic [FIFO_LOG2:0]  fifo_level,
    output logic [1:0]          dbg_state
);
    // Handshakes: a command is master_read with address/burstcount held until a cycle with
    // master_waitrequest low; every master_readdatavalid cycle carries one beat; rd_req pops
    // the head word only when the FIFO is not empty.
    localparam int DEPTH     = 1 << FIFO_LOG2;
    localparam int MAX_BURST = 1 << BURST_LOG2;
    localparam int OUT_W     = FIFO_LOG2 + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0]  BEAT_BYTES  = ADDR_W'(DATA_W / 8);
    localparam logic [FIFO_LOG2:0] FULL_LEVEL  = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [31:0]        MAX_BURST_W = 32'(MAX_BURST);

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic                stride_en_q, stride_en_d;
    logic [31:0]         wti_q, wti_d;
    logic [31:0]         wtr_q, wtr_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic [BURST_LOG2:0] burst_q, burst_d;
    logic                abort_pend_q, abort_pend_d;
    logic                overflow_q, overflow_d;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG2:0]   level_q;

    logic             live, accept, beat_seen, fifo_full, push, pop, flush, credit_ok;
    logic [31:0]      len_w;
    logic [OUT_W-1:0] out_sum;

    assign live      = (state_q == S_RUN) || (state_q == S_REQ);
    assign accept    = (state_q == S_REQ) && !master_waitrequest;
    assign beat_seen = master_readdatavalid && (state_q != S_IDLE);
    assign fifo_full = (level_q == FULL_LEVEL);
    assign push      = master_readdatavalid && live && !fifo_full;
    assign pop       = rd_req && (level_q != '0);

    always_comb begin
        len_w     = stride_en_q ? 32'd1 : ((wti_q > MAX_BURST_W) ? MAX_BURST_W : wti_q);
        credit_ok = (34'(level_q) + 34'(out_q) + 34'(len_w)) <= 34'(DEPTH);
        out_sum   = out_q + (accept ? OUT_W'(burst_q) : '0);
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        stride_d     = stride_q;
        stride_en_d  = stride_en_q;
        wti_d        = wti_q;
        wtr_d        = wtr_q;
        burst_d      = burst_q;
        abort_pend_d = abort_pend_q;
        flush        = 1'b0;
        overflow_d   = overflow_q | (master_readdatavalid && live && fifo_full);
        out_d        = out_sum;
        // Acceptance and a returning beat in the same cycle both land in the counters.
        if (beat_seen && out_sum != '0) out_d = out_sum - OUT_W'(1);
        if (master_readdatavalid && live && wtr_q != '0) wtr_d = wtr_q - 32'd1;
        if (accept) begin
            wti_d  = wti_q - 32'(burst_q);
            addr_d = addr_q + (stride_en_q ? stride_q : ADDR_W'(burst_q) * BEAT_BYTES);
        end
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    addr_d       = base_addr;
                    stride_d     = stride;
                    stride_en_d  = stride_en;
                    wti_d        = num_words;
                    wtr_d        = num_words;
                    out_d        = '0;
                    abort_pend_d = 1'b0;
                    if (num_words != '0) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_DRAIN;
                end else if (wti_q == '0 && out_q == '0 && wtr_q == '0) begin
                    state_d = S_IDLE;
                end else if (wti_q != '0 && credit_ok) begin
                    burst_d = len_w[BURST_LOG2:0];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (abort) abort_pend_d = 1'b1;
                if (accept) begin
                    abort_pend_d = 1'b0;
                    state_d      = (abort || abort_pend_q) ? S_DRAIN : S_RUN;
                end
            end
            S_DRAIN: begin
                if (out_q == '0) begin
                    flush   = 1'b1;
                    wti_d   = '0;
                    wtr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            stride_q     <= '0;
            stride_en_q  <= 1'b0;
            wti_q        <= '0;
            wtr_q        <= '0;
            out_q        <= '0;
            burst_q      <= '0;
            abort_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            stride_q     <= stride_d;
            stride_en_q  <= stride_en_d;
            wti_q        <= wti_d;
            wtr_q        <= wtr_d;
            out_q        <= out_d;
            burst_q      <= burst_d;
            abort_pend_q <= abort_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_LOG2'(1);
            if (push && !pop)      level_q <= level_q + (FIFO_LOG2 + 1)'(1);
            else if (pop && !push) level_q <= level_q - (FIFO_LOG2 + 1)'(1);
        end
    end

    // Storage carries no reset; the empty flag gates what the consumer sees.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= master_readdata;
    end

    assign rd_data           = (level_q == '0) ? '0 : mem[rd_ptr_q];
    assign fifo_empty        = (level_q == '0);
    assign fifo_level        = level_q;
    assign overflow          = overflow_q;
    assign master_read       = (state_q == S_REQ);
    assign master_address    = addr_q;
    assign master_burstcount = burst_q;
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_IDLE);
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_dram_stream_reader.sv
// Random and directed jobs against a job-level model of the read engine; a slave model answers
// the Avalon bus and a monitor checks every popped word and every accepted command.
module tb_dram_stream_reader;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 3;
  localparam int FL = 4;
  localparam int DEPTH = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, stride_en = 1'b0, abort = 1'b0;
  logic [AW-1:0] base_addr = '0, stride = '0;
  logic [31:0] num_words = '0;
  logic busy, done, overflow, master_read, fifo_empty;
  logic [AW-1:0] master_address;
  logic [BL:0] master_burstcount;
  logic [DW-1:0] master_readdata = '0;
  logic master_waitrequest = 1'b0, master_readdatavalid = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] rd_data;
  logic [FL:0] fifo_level;
  logic [1:0] dbg_state;

  dram_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .BURST_LOG2(BL), .FIFO_LOG2(FL)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .stride_en(stride_en), .stride(stride), .abort(abort), .busy(busy), .done(done),
    .overflow(overflow), .master_address(master_address), .master_read(master_read),
    .master_burstcount(master_burstcount), .master_readdata(master_readdata),
    .master_waitrequest(master_waitrequest), .master_readdatavalid(master_readdatavalid),
    .rd_req(rd_req), .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .dbg_state(dbg_state)
  );

  int tests = 0, fails = 0;
  logic [DW-1:0] exp_q[$];
  logic [31:0] exp_cmd_a[$];
  logic [31:0] exp_cmd_l[$];
  logic [31:0] pend_q[$];
  int tb_out = 0, cmd_cnt = 0, acc_words = 0, beats_cnt = 0, lvl7_seen = 0;
  int wr_rand = 0, hold_next = 0, beat_gap = 0, cons_mode = 0;
  bit beat_en = 1'b1, in_abort = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: expected command sequence and word stream of a whole job.
  task automatic plan_job(input logic [31:0] base, input int n, input bit sen,
                          input logic [31:0] str, input bit push_data);
    logic [31:0] a;
    int rem, len;
    a = base;
    rem = n;
    while (rem > 0) begin
      len = sen ? 1 : ((rem > 8) ? 8 : rem);
      exp_cmd_a.push_back(a);
      exp_cmd_l.push_back(len);
      for (int i = 0; i < len; i++)
        if (push_data) exp_q.push_back(mem_fn(a + 32'(4 * i)));
      a = sen ? a + str : a + 32'(4 * len);
      rem -= len;
    end
  endtask

  task automatic run_job(input logic [31:0] base, input int n, input bit sen, input logic [31:0] str);
    @(negedge clk);
    base_addr = base; num_words = n; stride_en = sen; stride = str; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (!(done && exp_q.size() == 0 && pend_q.size() == 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, n < limit, 1'b1);
    check({name, "_cmds_all_seen"}, exp_cmd_a.size(), 0);
  endtask

  // Avalon slave: waitrequest, command checking, in-order beat return.
  logic stall_prev = 1'b0;
  logic [31:0] stall_addr;
  logic [BL:0] stall_bc;
  int hold_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      master_waitrequest = 1'b0;
      master_readdatavalid = 1'b0;
      pend_q.delete();
      tb_out = 0;
      stall_prev = 1'b0;
      hold_cnt = 0;
    end else begin
      if (stall_prev) begin
        check("wait_read_held", master_read, 1'b1);
        check("wait_addr_stable", master_address, stall_addr);
        check("wait_len_stable", master_burstcount, stall_bc);
      end
      if (master_read) begin
        if (!stall_prev && hold_next > 0) begin hold_cnt = hold_next; hold_next = 0; end
        if (hold_cnt > 0) begin master_waitrequest = 1'b1; hold_cnt--; end
        else master_waitrequest = (wr_rand != 0) && ($urandom_range(0, 2) == 0);
      end else begin
        master_waitrequest = 1'($urandom_range(0, 1));
      end
      if (master_read && !master_waitrequest) begin
        cmd_cnt++;
        acc_words += int'(master_burstcount);
        check("credit", (int'(fifo_level) + tb_out + int'(master_burstcount)) <= DEPTH, 1'b1);
        if (exp_cmd_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL cmd_unexpected: got addr 0x%0h len %0d, expected no command",
                   master_address, master_burstcount);
        end else begin
          check("cmd_addr", master_address, exp_cmd_a.pop_front());
          check("cmd_len", master_burstcount, exp_cmd_l.pop_front());
        end
        for (int i = 0; i < int'(master_burstcount); i++) pend_q.push_back(master_address + 32'(4 * i));
        tb_out += int'(master_burstcount);
        stall_prev = 1'b0;
      end else if (master_read) begin
        stall_prev = 1'b1;
        stall_addr = master_address;
        stall_bc = master_burstcount;
      end else begin
        stall_prev = 1'b0;
      end
      if (beat_en && pend_q.size() > 0 && $urandom_range(0, 99) >= beat_gap) begin
        master_readdatavalid = 1'b1;
        master_readdata = mem_fn(pend_q.pop_front());
        tb_out--;
        beats_cnt++;
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata = $urandom;
      end
    end
  end

  // Consumer and scoreboard monitor.
  always @(negedge clk) begin
    if (reset) rd_req = 1'b0;
    else begin
      case (cons_mode)
        1: rd_req = 1'($urandom_range(0, 1));
        2: rd_req = (fifo_level >= 7);
        default: rd_req = 1'b0;
      endcase
      if (rd_req && !fifo_empty) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: got 0x%0h, expected no word", rd_data);
        end else check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  // Simultaneous push and pop at level 7 must leave the level unchanged.
  bit snap_both = 1'b0;
  always @(negedge clk) begin
    #2;
    if (snap_both && !reset) begin
      check("pushpop_level7", fifo_level, 7);
      lvl7_seen++;
    end
    snap_both = !reset && busy && !in_abort && master_readdatavalid && rd_req && (fifo_level == 7);
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b1);
    check("rst_read", master_read, 1'b0);
    check("rst_addr", master_address, 0);
    check("rst_len", master_burstcount, 0);
    check("rst_level", fifo_level, 0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b0;

    // contiguous 20 words from 0x1000
    cons_mode = 1;
    plan_job(32'h1000, 20, 1'b0, 0, 1'b1);
    run_job(32'h1000, 20, 1'b0, 0);
    wait_idle("contig", 1000);
    check("contig_done", done, 1'b1);

    // strided: three single reads 0x100 apart
    plan_job(32'h0, 3, 1'b1, 32'h100, 1'b1);
    run_job(32'h0, 3, 1'b1, 32'h100);
    wait_idle("strided", 1000);

    // waitrequest held for five cycles on one burst
    begin
      int c0;
      c0 = cmd_cnt;
      hold_next = 5;
      plan_job(32'h2000, 8, 1'b0, 0, 1'b1);
      run_job(32'h2000, 8, 1'b0, 0);
      wait_idle("waitreq", 1000);
      check("waitreq_one_burst", cmd_cnt - c0, 1);
    end

    // backpressure: idle consumer, 40 words
    begin
      int a0;
      a0 = acc_words;
      cons_mode = 0;
      plan_job(32'h3000, 40, 1'b0, 0, 1'b1);
      run_job(32'h3000, 40, 1'b0, 0);
      repeat (60) @(negedge clk);
      check("bp_reserved_words", acc_words - a0, 16);
      check("bp_level_full", fifo_level, 16);
      check("bp_busy", busy, 1'b1);
      cons_mode = 1;
      wait_idle("bp", 2000);
      check("bp_overflow", overflow, 1'b0);
    end

    // zero-length job
    run_job(32'h9000, 0, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      check("zero_no_read", master_read, 1'b0);
      check("zero_done", done, 1'b1);
      @(negedge clk);
    end

    // consumer pops exactly when level reaches 7 while beats stream in
    cons_mode = 2;
    plan_job(32'h4000, 12, 1'b0, 0, 1'b1);
    run_job(32'h4000, 12, 1'b0, 0);
    repeat (60) @(negedge clk);
    cons_mode = 1;
    wait_idle("lvl7", 1000);
    check("lvl7_event_seen", lvl7_seen > 0, 1'b1);

    // randomized jobs with bus and consumer noise
    wr_rand = 1;
    beat_gap = 30;
    for (int j = 0; j < 6; j++) begin
      logic [31:0] b, s;
      int n;
      bit se;
      b = $urandom & 32'hFFFF_FFFC;
      s = 32'($urandom_range(1, 64) * 4);
      n = $urandom_range(1, 30);
      se = 1'($urandom_range(0, 1));
      plan_job(b, n, se, s, 1'b1);
      run_job(b, n, se, s);
      wait_idle("random", 3000);
    end

    // abort with two bursts outstanding
    begin
      int c0, b0, n;
      wr_rand = 0;
      beat_gap = 0;
      beat_en = 1'b0;
      cons_mode = 0;
      c0 = acc_words;
      plan_job(32'h5000, 40, 1'b0, 0, 1'b0);
      run_job(32'h5000, 40, 1'b0, 0);
      n = 0;
      while (acc_words - c0 < 16 && n < 200) begin @(negedge clk); n++; end
      check("abort_two_bursts", acc_words - c0, 16);
      repeat (3) @(negedge clk);
      c0 = cmd_cnt;
      b0 = beats_cnt;
      in_abort = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      beat_en = 1'b1;
      n = 0;
      while (!(done && pend_q.size() == 0) && n < 300) begin @(negedge clk); n++; end
      check("abort_complete", n < 300, 1'b1);
      check("abort_no_new_cmds", cmd_cnt - c0, 0);
      check("abort_beats_discarded", beats_cnt - b0, 16);
      check("abort_level", fifo_level, 0);
      check("abort_empty", fifo_empty, 1'b1);
      check("abort_idle", done, 1'b1);
      exp_cmd_a.delete();
      exp_cmd_l.delete();
      in_abort = 1'b0;
    end

    // reset in the middle of a job, then a fresh job
    beat_gap = 30;
    cons_mode = 1;
    plan_job(32'h6000, 20, 1'b0, 0, 1'b1);
    run_job(32'h6000, 20, 1'b0, 0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_read", master_read, 1'b0);
    check("midrst_level", fifo_level, 0);
    check("midrst_empty", fifo_empty, 1'b1);
    check("midrst_done", done, 1'b1);
    exp_q.delete();
    exp_cmd_a.delete();
    exp_cmd_l.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    plan_job(32'h7000, 5, 1'b0, 0, 1'b1);
    run_job(32'h7000, 5, 1'b0, 0);
    wait_idle("post_reset", 1000);

    check("final_overflow", overflow, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
